// File: rtl/gmrr_pkg.sv
// Shared GMRR constants and helpers for the tap-readout RAM.
package gmrr_pkg;

    // Widest tap fan-out any GMRR datapath consumes.
    localparam int unsigned GMRR_MAX_NTAPS = 8;

    // Guard bits above the address so that a + k never overflows before wrapping.
    localparam int unsigned GMRR_TAP_GUARD_BITS = 4;

    // Tap-index width for a given address width (AWIDTH + 4).
    function automatic int unsigned gmrr_tap_idx_w(input int unsigned awidth);
        return awidth + GMRR_TAP_GUARD_BITS;
    endfunction

endpackage

// File: rtl/ram_to_fifo_taps_if.sv
// Bus bundle for ram_to_fifo_taps: config stream, address stream, tap output stream.
// Optional o_tuser member exists only when RAM_TO_FIFO_TAPS_OOR_FLAG_EN is defined.
interface ram_to_fifo_taps_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned NTAPS  = 2
);
    logic [DWIDTH-1:0]       config_tdata;
    logic                    config_tlast;
    logic                    config_tvalid;
    logic                    config_tready;

    logic [AWIDTH-1:0]       i_tdata;
    logic                    i_tlast;
    logic                    i_tvalid;
    logic                    i_tready;

    logic [NTAPS*DWIDTH-1:0] o_tdata;
    logic                    o_tlast;
    logic                    o_tvalid;
    logic                    o_tready;
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
    logic [NTAPS-1:0]        o_tuser;
`endif

    // Block side.
    modport slave (
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
        output o_tuser,
`endif
        input  config_tdata, config_tlast, config_tvalid,
        output config_tready,
        input  i_tdata, i_tlast, i_tvalid,
        output i_tready,
        output o_tdata, o_tlast, o_tvalid,
        input  o_tready
    );

    // Environment side.
    modport master (
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
        input  o_tuser,
`endif
        output config_tdata, config_tlast, config_tvalid,
        input  config_tready,
        output i_tdata, i_tlast, i_tvalid,
        input  i_tready,
        input  o_tdata, o_tlast, o_tvalid,
        output o_tready
    );

endinterface

// File: rtl/ram_2port.sv
// Simple dual-port RAM: write port A, registered read port B with enable.
// Read-first: a same-cycle write to the read address returns the old word.
module ram_2port #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clka,
    input  logic              wea,
    input  logic [AWIDTH-1:0] addra,
    input  logic [DWIDTH-1:0] dia,
    input  logic              clkb,
    input  logic              enb,
    input  logic [AWIDTH-1:0] addrb,
    output logic [DWIDTH-1:0] dob
);
    logic [DWIDTH-1:0] r_mem [2**AWIDTH];
    logic [DWIDTH-1:0] r_dob;

    // Write port.
    always_ff @(posedge clka) begin
        if (wea) begin
            r_mem[addra] <= dia;
        end
    end

    // Read port; holds its word while enb is low.
    always_ff @(posedge clkb) begin
        if (enb) begin
            r_dob <= r_mem[addrb];
        end
    end

    assign dob = r_dob;

endmodule

// File: rtl/ram_to_fifo_taps.sv
// Coefficient RAM with multi-tap streamed readout: each address beat returns NTAPS
// consecutive table words (modulo the loaded table length) in one wide beat.
// Optional feature macro: RAM_TO_FIFO_TAPS_OOR_FLAG_EN adds a per-tap out-of-range flag.
module ram_to_fifo_taps
    import gmrr_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned NTAPS  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    ram_to_fifo_taps_if.slave bus
);
    localparam int unsigned IW = gmrr_tap_idx_w(AWIDTH);
    localparam logic [AWIDTH:0] LEN_FULL = {1'b1, {AWIDTH{1'b0}}};

    if (NTAPS < 1 || NTAPS > GMRR_MAX_NTAPS) begin : g_bad_ntaps
        $error("ram_to_fifo_taps: NTAPS out of range");
    end

    logic [AWIDTH-1:0]              r_write_addr;
    logic [AWIDTH:0]                r_len;
    logic [IW-1:0]                  w_len_x;
    logic [IW-1:0]                  w_base_x;
    logic                           w_cfg_we;
    logic                           w_s1_adv;
    logic                           w_s2_adv;
    logic                           w_accept;
    logic                           r_s1_valid;
    logic                           r_s1_last;
    logic [NTAPS-1:0]               r_s1_oor;
    logic [NTAPS-1:0]               w_oor;
    logic [NTAPS-1:0][AWIDTH-1:0]   w_tap_addr;
    logic [NTAPS-1:0][DWIDTH-1:0]   w_ram_q;
    logic [NTAPS-1:0][DWIDTH-1:0]   w_masked;
    logic                           r_s2_valid;
    logic                           r_o_tlast;
    logic [NTAPS*DWIDTH-1:0]        r_o_tdata;
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
    logic [NTAPS-1:0]               r_o_tuser;
`endif

    // Clear blocks table writes so the RAM is left exactly as it was.
    assign w_cfg_we = bus.config_tvalid & ~clear;
    assign w_len_x  = IW'(r_len);
    assign w_base_x = IW'(bus.i_tdata);

    // A stage advances when the stage after it is empty or being consumed.
    assign w_s2_adv = ~r_s2_valid | bus.o_tready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign w_accept = bus.i_tvalid & w_s1_adv;

    // Write counter and table length; length only moves on a tlast beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write_addr <= '0;
            r_len        <= LEN_FULL;
        end else if (clear) begin
            r_write_addr <= '0;
            r_len        <= LEN_FULL;
        end else if (w_cfg_we) begin
            if (bus.config_tlast) begin
                r_len        <= {1'b0, r_write_addr} + {{AWIDTH{1'b0}}, 1'b1};
                r_write_addr <= '0;
            end else begin
                r_write_addr <= r_write_addr + AWIDTH'(1);
            end
        end
    end

    // Per-tap index (single wrap), range check, RAM copy and zero masking.
    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        logic [IW-1:0] w_sum;
        logic [IW-1:0] w_wrap;

        assign w_sum         = w_base_x + IW'(k);
        assign w_wrap        = (w_sum >= w_len_x) ? (w_sum - w_len_x) : w_sum;
        assign w_oor[k]      = (w_wrap >= w_len_x) | (w_base_x >= w_len_x);
        assign w_tap_addr[k] = w_wrap[AWIDTH-1:0];
        assign w_masked[k]   = r_s1_oor[k] ? '0 : w_ram_q[k];

        // Read enable only on accept, so a stalled S1 keeps its RAM word.
        ram_2port #(
            .DWIDTH(DWIDTH),
            .AWIDTH(AWIDTH)
        ) u_ram (
            .clka  (clk),
            .wea   (w_cfg_we),
            .addra (r_write_addr),
            .dia   (bus.config_tdata),
            .clkb  (clk),
            .enb   (w_accept),
            .addrb (w_tap_addr[k]),
            .dob   (w_ram_q[k])
        );
    end

    // S1 side-band (valid/last/range) and S2 output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_oor   <= '0;
            r_s2_valid <= 1'b0;
            r_o_tdata  <= '0;
            r_o_tlast  <= 1'b0;
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
            r_o_tuser  <= '0;
`endif
        end else if (clear) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_oor   <= '0;
            r_s2_valid <= 1'b0;
            r_o_tdata  <= '0;
            r_o_tlast  <= 1'b0;
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
            r_o_tuser  <= '0;
`endif
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_last <= bus.i_tlast;
                    r_s1_oor  <= w_oor;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_o_tdata <= w_masked;
                    r_o_tlast <= r_s1_last;
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
                    r_o_tuser <= r_s1_oor;
`endif
                end
            end
        end
    end

    assign bus.config_tready = 1'b1;
    assign bus.i_tready      = w_s1_adv;
    assign bus.o_tvalid      = r_s2_valid;
    assign bus.o_tdata       = r_o_tdata;
    assign bus.o_tlast       = r_o_tlast;
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
    assign bus.o_tuser       = r_o_tuser;
`endif

endmodule

// File: tb/tb_ram_to_fifo_taps.sv
// Bench for ram_to_fifo_taps: directed vector table, corner sequences and a
// randomized run against a scoreboard model of the table lookup rules.
module tb_ram_to_fifo_taps;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int NT    = 2;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [NT*DW-1:0] data;
        logic [NT-1:0]    oor;
        logic             last;
    } exp_t;

    typedef struct {
        int               addr;
        logic [NT*DW-1:0] data;
        logic [NT-1:0]    oor;
    } vec_t;

    logic clk;
    logic reset_n;
    logic clear;

    ram_to_fifo_taps_if #(.DWIDTH(DW), .AWIDTH(AW), .NTAPS(NT)) bus ();

    ram_to_fifo_taps #(.DWIDTH(DW), .AWIDTH(AW), .NTAPS(NT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_len = DEPTH;
    int            m_wa  = 0;
    exp_t          q[$];

    // Monitor bookkeeping.
    int            cyc = 0;
    bit            acc_seen = 0;
    bit            stall_prev = 0;
    logic [NT*DW-1:0] held_data;
    logic          held_last;
    int            first_acc_cyc = -1;
    int            first_out_cyc = -1;
    int            last_out_cyc  = -1;
    int            out_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lookup rule: tap k is in range iff a < len and a+k < 2*len; then word (a+k) mod len.
    function automatic exp_t model(input int a, input logic l);
        exp_t e;
        e.data = '0;
        e.oor  = '0;
        e.last = l;
        for (int k = 0; k < NT; k++) begin
            if (a >= m_len || a + k >= 2 * m_len) e.oor[k] = 1'b1;
            else e.data[k*DW +: DW] = m_mem[(a + k) % m_len];
        end
        return e;
    endfunction

    // Negedge monitor: scoreboard, hold-while-stalled check, model updates.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset_n) begin
            q.delete();
            m_len = DEPTH;
            m_wa = 0;
            stall_prev = 0;
            acc_seen = 0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_valid", 128'(bus.o_tvalid), 128'(1));
                check("stall_hold_data", 128'(bus.o_tdata), 128'(held_data));
                check("stall_hold_last", 128'(bus.o_tlast), 128'(held_last));
            end
            stall_prev = bus.o_tvalid && !bus.o_tready && !clear;
            held_data = bus.o_tdata;
            held_last = bus.o_tlast;
            if (bus.o_tvalid && bus.o_tready) begin
                out_cnt++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                if (q.size() == 0) begin
                    check("unexpected_beat", 128'(1), 128'(0));
                end else begin
                    e = q.pop_front();
                    check("sb_data", 128'(bus.o_tdata), 128'(e.data));
                    check("sb_last", 128'(bus.o_tlast), 128'(e.last));
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
                    check("sb_oor", 128'(bus.o_tuser), 128'(e.oor));
`endif
                end
            end
            acc_seen = bus.i_tvalid && bus.i_tready;
            if (clear) begin
                q.delete();
                m_len = DEPTH;
                m_wa = 0;
            end else begin
                if (acc_seen) begin
                    if (first_acc_cyc < 0) first_acc_cyc = cyc;
                    q.push_back(model(int'(bus.i_tdata), bus.i_tlast));
                end
                // Reads above used the pre-write table: same-cycle read returns old data.
                if (bus.config_tvalid) begin
                    m_mem[m_wa] = bus.config_tdata;
                    if (bus.config_tlast) begin
                        m_len = m_wa + 1;
                        m_wa = 0;
                    end else begin
                        m_wa = (m_wa + 1) % DEPTH;
                    end
                end
            end
        end
    end

    task automatic cfg_write(input logic [DW-1:0] d, input logic l);
        @(posedge clk); #1;
        bus.config_tdata  = d;
        bus.config_tlast  = l;
        bus.config_tvalid = 1'b1;
    endtask

    task automatic cfg_idle();
        @(posedge clk); #1;
        bus.config_tvalid = 1'b0;
        bus.config_tlast  = 1'b0;
    endtask

    // One address beat with o_tready high; returns the output beat.
    task automatic xfer(input int a, output logic [NT*DW-1:0] d, output logic [NT-1:0] u);
        bit got = 0;
        @(posedge clk); #1;
        bus.i_tdata  = AW'(a);
        bus.i_tlast  = 1'b1;
        bus.i_tvalid = 1'b1;
        @(posedge clk); #1;
        bus.i_tvalid = 1'b0;
        d = '0;
        u = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.o_tvalid) begin
                got = 1;
                d = bus.o_tdata;
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
                u = bus.o_tuser;
`endif
            end
        end
        if (!got) check("xfer_timeout", 128'(0), 128'(1));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        #1;
        check(name, 128'(q.size()), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t             vecs[6];
        logic [NT*DW-1:0] d;
        logic [NT-1:0]    u;
        int               baddr[64];
        int               idx;
        int               guard;

        vecs[0] = '{addr: 3,  data: {32'hA000_0004, 32'hA000_0003}, oor: 2'b00};
        vecs[1] = '{addr: 15, data: {32'hA000_0000, 32'hA000_000F}, oor: 2'b00};
        vecs[2] = '{addr: 20, data: 64'h0,                          oor: 2'b11};
        vecs[3] = '{addr: 14, data: {32'hA000_000F, 32'hA000_000E}, oor: 2'b00};
        vecs[4] = '{addr: 16, data: 64'h0,                          oor: 2'b11};
        vecs[5] = '{addr: 0,  data: {32'hA000_0001, 32'hA000_0000}, oor: 2'b00};

        reset_n = 1'b0;
        clear = 1'b0;
        bus.config_tdata = '0;
        bus.config_tlast = 1'b0;
        bus.config_tvalid = 1'b0;
        bus.i_tdata = '0;
        bus.i_tlast = 1'b0;
        bus.i_tvalid = 1'b0;
        bus.o_tready = 1'b1;

        // Reset state.
        #12;
        check("rst_o_tvalid", 128'(bus.o_tvalid), 128'(0));
        check("rst_o_tdata", 128'(bus.o_tdata), 128'(0));
        check("rst_o_tlast", 128'(bus.o_tlast), 128'(0));
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_i_tready", 128'(bus.i_tready), 128'(1));
        check("cfg_tready", 128'(bus.config_tready), 128'(1));

        // Table of 16 words, then the vector table.
        for (int i = 0; i < 16; i++) cfg_write(32'hA000_0000 + DW'(i), i == 15);
        cfg_idle();
        foreach (vecs[i]) begin
            xfer(vecs[i].addr, d, u);
            check($sformatf("vec%0d_data", i), 128'(d), 128'(vecs[i].data));
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
            check($sformatf("vec%0d_oor", i), 128'(u), 128'(vecs[i].oor));
`endif
        end

        // Same-cycle write and read of address 5 returns the old word.
        for (int i = 0; i < 5; i++) cfg_write(32'hB000_0000 + DW'(i), 1'b0);
        @(posedge clk); #1;
        bus.config_tdata = 32'hB000_0005;
        bus.config_tlast = 1'b0;
        bus.config_tvalid = 1'b1;
        bus.i_tdata = AW'(5);
        bus.i_tlast = 1'b0;
        bus.i_tvalid = 1'b1;
        @(posedge clk); #1;
        bus.config_tvalid = 1'b0;
        bus.i_tvalid = 1'b0;
        for (int i = 0; i < 10 && !bus.o_tvalid; i++) @(negedge clk);
        check("rw_same_old", 128'(bus.o_tdata), 128'({32'hA000_0006, 32'hA000_0005}));
        for (int i = 6; i < 16; i++) cfg_write(32'hB000_0000 + DW'(i), i == 15);
        cfg_idle();
        xfer(5, d, u);
        check("rw_same_new", 128'(d), 128'({32'hB000_0006, 32'hB000_0005}));

        // len = 1: both taps fold onto word 0; address 1 is out of range.
        cfg_write(32'hC000_0000, 1'b1);
        cfg_idle();
        xfer(0, d, u);
        check("len1_data", 128'(d), 128'({32'hC000_0000, 32'hC000_0000}));
        xfer(1, d, u);
        check("len1_oor_data", 128'(d), 128'(0));
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
        check("len1_oor_flag", 128'(u), 128'(2'b11));
`endif
        drain("drain_directed");

        // 64 back-to-back beats on a random 37-word table.
        for (int i = 0; i < 37; i++) cfg_write($urandom, i == 36);
        cfg_idle();
        foreach (baddr[i]) baddr[i] = $urandom_range(0, 40);
        baddr[0] = 36;
        baddr[1] = 37;
        @(posedge clk); #1;
        first_acc_cyc = -1;
        first_out_cyc = -1;
        out_cnt = 0;
        idx = 0;
        bus.i_tvalid = 1'b1;
        bus.i_tlast = 1'b0;
        bus.i_tdata = AW'(baddr[0]);
        guard = 0;
        while (idx < 64 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
            if (acc_seen) idx++;
            if (idx < 64) bus.i_tdata = AW'(baddr[idx]);
            else bus.i_tvalid = 1'b0;
        end
        bus.i_tvalid = 1'b0;
        check("burst_accepts", 128'(idx), 128'(64));
        drain("drain_burst");
        check("burst_latency", 128'(first_out_cyc - first_acc_cyc), 128'(2));
        check("burst_count", 128'(out_cnt), 128'(64));
        check("burst_no_bubbles", 128'(last_out_cyc - first_out_cyc), 128'(63));

        // Random ready/valid with occasional table writes.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            bus.o_tready = ($urandom_range(0, 2) != 0);
            if (!bus.i_tvalid || acc_seen) begin
                bus.i_tvalid = ($urandom_range(0, 3) != 0);
                bus.i_tdata = AW'($urandom_range(0, 63));
                bus.i_tlast = 1'($urandom_range(0, 1));
            end
            bus.config_tvalid = ($urandom_range(0, 7) == 0);
            bus.config_tdata = $urandom;
            bus.config_tlast = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #1;
        bus.config_tvalid = 1'b0;
        bus.config_tlast = 1'b0;
        bus.o_tready = 1'b1;
        @(posedge clk); #1;
        bus.i_tvalid = 1'b0;
        drain("drain_random");

        // Synchronous clear with a stalled, full pipeline.
        bus.o_tready = 1'b0;
        bus.i_tvalid = 1'b1;
        bus.i_tdata = AW'(10);
        @(posedge clk); #1;
        bus.i_tdata = AW'(11);
        @(posedge clk); #1;
        bus.i_tvalid = 1'b0;
        @(negedge clk);
        check("clr_pre_valid", 128'(bus.o_tvalid), 128'(1));
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_empty", 128'(bus.o_tvalid), 128'(0));
        bus.o_tready = 1'b1;
        xfer(10, d, u);
        check("clr_reread", 128'(d), 128'({m_mem[11], m_mem[10]}));

        // Asynchronous reset mid-stream.
        bus.o_tready = 1'b0;
        bus.i_tvalid = 1'b1;
        bus.i_tdata = AW'(5);
        @(posedge clk); #1;
        bus.i_tdata = AW'(6);
        @(posedge clk); #1;
        bus.i_tvalid = 1'b0;
        @(posedge clk); #2;
        check("arst_pre_valid", 128'(bus.o_tvalid), 128'(1));
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_o_tvalid", 128'(bus.o_tvalid), 128'(0));
        check("arst_o_tdata", 128'(bus.o_tdata), 128'(0));
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        bus.o_tready = 1'b1;
        // Without a tlast the table length must be back at DEPTH.
        for (int i = 0; i < 64; i++) cfg_write($urandom, 1'b0);
        cfg_idle();
        xfer(50, d, u);
        check("arst_len_full", 128'(d), 128'({m_mem[51], m_mem[50]}));
`ifdef RAM_TO_FIFO_TAPS_OOR_FLAG_EN
        check("arst_len_full_oor", 128'(u), 128'(0));
`endif
        drain("drain_final");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
